// File: rtl/dram_cmd_sequencer.sv
// rtl/dram_cmd_sequencer.sv - per-request PRE/ACT/RD/WR sequencer with open-row table and tRP/tRCD/CAS timing
module dram_cmd_sequencer #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RP         = 3,
    parameter int T_RCD        = 3,
    parameter int T_CAS        = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank_id_i,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row_id_i,
    input  logic [$clog2(NUM_OF_COLS)-1:0]  req_col_id_i,
    output logic                            cmd_valid_o,
    output logic [2:0]                      cmd_o,
    output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank_o,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row_o,
    output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col_o,
    output logic                            done_o,
    output logic                            done_hit_o
);
    localparam int BW    = $clog2(NUM_OF_BANKS);
    localparam int RW_W  = $clog2(NUM_OF_ROWS);
    localparam int CW    = $clog2(NUM_OF_COLS);
    localparam int T_MX1 = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int T_MAX = (T_MX1 > T_CAS) ? T_MX1 : T_CAS;
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_CAS
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              hit_q, hit_d;
    logic [BW-1:0]     bank_q, bank_d;
    logic [RW_W-1:0]   row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              done_q, done_d;
    logic              done_hit_q, done_hit_d;

    logic              open_q    [NUM_OF_BANKS];
    logic [RW_W-1:0]   row_tbl_q [NUM_OF_BANKS];

    logic              req_open;
    logic              req_hit;

    assign req_open = open_q[req_bank_id_i];
    assign req_hit  = req_open && (row_tbl_q[req_bank_id_i] == req_row_id_i);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        hit_d      = hit_q;
        bank_d     = bank_q;
        row_d      = row_q;
        col_d      = col_q;
        done_d     = 1'b0;
        done_hit_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d   = req_we_i;
                    hit_d  = req_hit;
                    bank_d = req_bank_id_i;
                    row_d  = req_row_id_i;
                    col_d  = req_col_id_i;
                    if (req_hit)       state_d = S_RW;
                    else if (req_open) state_d = S_PRE;
                    else               state_d = S_ACT;
                end
            end
            S_PRE: begin
                if (T_RP == 1) begin
                    state_d = S_ACT;
                end else begin
                    cnt_d   = CNT_W'(T_RP - 1);
                    state_d = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) state_d = S_ACT;
            end
            S_ACT: begin
                if (T_RCD == 1) begin
                    state_d = S_RW;
                end else begin
                    cnt_d   = CNT_W'(T_RCD - 1);
                    state_d = S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) state_d = S_RW;
            end
            S_RW: begin
                if (T_CAS == 1) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    done_hit_d = hit_q;
                end else begin
                    cnt_d   = CNT_W'(T_CAS - 1);
                    state_d = S_WAIT_CAS;
                end
            end
            S_WAIT_CAS: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    done_hit_d = hit_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            done_q     <= 1'b0;
            done_hit_q <= 1'b0;
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                open_q[i]    <= 1'b0;
                row_tbl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            hit_q      <= hit_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            done_q     <= done_d;
            done_hit_q <= done_hit_d;
            // Table follows the commands actually issued, so it tracks the device's page state.
            if (state_q == S_PRE) begin
                open_q[bank_q] <= 1'b0;
            end
            if (state_q == S_ACT) begin
                open_q[bank_q]    <= 1'b1;
                row_tbl_q[bank_q] <= row_q;
            end
        end
    end

    always_comb begin
        cmd_valid_o = 1'b0;
        cmd_o       = CMD_NOP;
        cmd_bank_o  = '0;
        cmd_row_o   = '0;
        cmd_col_o   = '0;
        case (state_q)
            S_PRE: begin
                cmd_valid_o = 1'b1;
                cmd_o       = CMD_PRE;
                cmd_bank_o  = bank_q;
            end
            S_ACT: begin
                cmd_valid_o = 1'b1;
                cmd_o       = CMD_ACT;
                cmd_bank_o  = bank_q;
                cmd_row_o   = row_q;
            end
            S_RW: begin
                cmd_valid_o = 1'b1;
                cmd_o       = we_q ? CMD_WR : CMD_RD;
                cmd_bank_o  = bank_q;
                cmd_col_o   = col_q;
            end
            default: ;
        endcase
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign done_o      = done_q;
    assign done_hit_o  = done_hit_q;
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// tb/tb_dram_cmd_sequencer.sv - table-driven self-checking bench for dram_cmd_sequencer
module tb_dram_cmd_sequencer;
    localparam int T_RP  = 3;
    localparam int T_RCD = 3;
    localparam int T_CAS = 2;
    localparam int NV    = 14;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [2:0] req_bank_id;
    logic [6:0] req_row_id;
    logic [2:0] req_col_id;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [2:0] cmd_bank;
    logic [6:0] cmd_row;
    logic [2:0] cmd_col;
    logic       done;
    logic       done_hit;

    int total = 0;
    int bad   = 0;

    dram_cmd_sequencer #(
        .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8),
        .T_RP(T_RP), .T_RCD(T_RCD), .T_CAS(T_CAS)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_bank_id_i(req_bank_id), .req_row_id_i(req_row_id), .req_col_id_i(req_col_id),
        .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_bank_o(cmd_bank),
        .cmd_row_o(cmd_row), .cmd_col_o(cmd_col),
        .done_o(done), .done_hit_o(done_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [2:0] bank;
        logic [6:0] row;
        logic [2:0] col;
        bit         pre;
        bit         hit;
        int         lat;
        bit         hold;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic we, input logic [2:0] b, input logic [6:0] r,
                                input logic [2:0] c, input bit pre, input bit hit,
                                input int lat, input bit hold);
        vec_t v;
        v.we = we; v.bank = b; v.row = r; v.col = c;
        v.pre = pre; v.hit = hit; v.lat = lat; v.hold = hold;
        return v;
    endfunction

    // {cmd_valid, cmd, bank, row, col, ready, done, done_hit}
    function automatic logic [20:0] obs();
        return {cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, req_ready, done, done_hit};
    endfunction

    task automatic chk(input string name, input logic [20:0] got, input logic [20:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        req_we      = v.we;
        req_bank_id = v.bank;
        req_row_id  = v.row;
        req_col_id  = v.col;
    endtask

    task automatic apply(input int idx);
        vec_t v;
        int t_act, t_rw;
        logic       e_valid, e_ready, e_done, e_hit;
        logic [2:0] e_cmd, e_bank, e_col;
        logic [6:0] e_row;
        v = vecs[idx];
        drive(v);
        req_valid = 1'b1;
        chk($sformatf("v%0d_ready_at_accept", idx), {20'd0, req_ready}, 21'd1);
        step();
        if (v.hold && idx + 1 < NV) drive(vecs[idx + 1]);
        else req_valid = 1'b0;
        t_act = v.pre ? 1 + T_RP : 1;
        t_rw  = v.hit ? 1 : t_act + T_RCD;
        for (int k = 1; k <= v.lat; k++) begin
            e_valid = 0; e_cmd = 0; e_bank = 0; e_row = 0; e_col = 0;
            e_ready = 0; e_done = 0; e_hit = 0;
            if (v.pre && k == 1) begin
                e_valid = 1; e_cmd = 3'd4; e_bank = v.bank;
            end
            if (!v.hit && k == t_act) begin
                e_valid = 1; e_cmd = 3'd1; e_bank = v.bank; e_row = v.row;
            end
            if (k == t_rw) begin
                e_valid = 1; e_cmd = v.we ? 3'd3 : 3'd2; e_bank = v.bank; e_col = v.col;
            end
            if (k == v.lat) begin
                e_ready = 1; e_done = 1; e_hit = v.hit;
            end
            chk($sformatf("v%0d_cyc%0d", idx, k), obs(),
                {e_valid, e_cmd, e_bank, e_row, e_col, e_ready, e_done, e_hit});
            if (k < v.lat) step();
        end
    endtask

    initial begin
        //            we  bank row  col pre hit lat hold
        vecs[0]  = mk(0, 3'd2, 7'd5,   3'd3, 0, 0, 6, 0);
        vecs[1]  = mk(1, 3'd2, 7'd5,   3'd7, 0, 1, 3, 0);
        vecs[2]  = mk(0, 3'd2, 7'd9,   3'd0, 1, 0, 9, 0);
        vecs[3]  = mk(0, 3'd5, 7'd9,   3'd1, 0, 0, 6, 0);
        vecs[4]  = mk(0, 3'd2, 7'd9,   3'd4, 0, 1, 3, 1);
        vecs[5]  = mk(1, 3'd2, 7'd9,   3'd5, 0, 1, 3, 1);
        vecs[6]  = mk(0, 3'd2, 7'd9,   3'd6, 0, 1, 3, 0);
        vecs[7]  = mk(1, 3'd5, 7'd100, 3'd2, 1, 0, 9, 0);
        vecs[8]  = mk(0, 3'd2, 7'd9,   3'd1, 0, 1, 3, 0);
        vecs[9]  = mk(0, 3'd0, 7'd0,   3'd0, 0, 0, 6, 0);
        vecs[10] = mk(0, 3'd7, 7'd127, 3'd7, 0, 0, 6, 0);
        vecs[11] = mk(1, 3'd7, 7'd127, 3'd0, 0, 1, 3, 0);
        vecs[12] = mk(0, 3'd3, 7'd4,   3'd1, 0, 0, 6, 0);
        vecs[13] = mk(0, 3'd2, 7'd9,   3'd2, 0, 0, 6, 0);

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_bank_id = '0; req_row_id = '0; req_col_id = '0;
        #1;
        chk("reset_outputs", obs(), 21'b100);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", obs(), 21'b100);

        for (int i = 0; i < 12; i++) apply(i);

        // Reset during WAIT_RCD: bank 3 row 4 gets ACT, then abort.
        drive(vecs[12]);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rst_seq_act", obs(), {1'b1, 3'd1, 3'd3, 7'd4, 3'd0, 3'b000});
        step();
        chk("rst_seq_wait_rcd", obs(), 21'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_seq_async", obs(), 21'b100);
        step();
        chk("rst_seq_held", obs(), 21'b100);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("rst_seq_no_done%0d", k), obs(), 21'b100);
        end
        apply(12);
        apply(13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_cmd_sequencer.md
Name: dram_cmd_sequencer

Overview:
Sits directly downstream of the DRAM address translator. It consumes one decoded request (bank/row/col plus a write flag) at a time and issues the DRAM command sequence that request needs: PRE, ACT, then RD or WR. It keeps an open-row table for every bank and enforces the tRP, tRCD and CAS delays with a down-counter. It signals completion with a single-cycle done pulse.

Parameters:
NUM_OF_BANKS, 8, number of banks; bank field width is $clog2(NUM_OF_BANKS)
NUM_OF_ROWS, 128, rows per bank; row field width is $clog2(NUM_OF_ROWS)
NUM_OF_COLS, 8, columns per row; col field width is $clog2(NUM_OF_COLS)
T_RP, 3, cycles from PRE to ACT, must be >= 1
T_RCD, 3, cycles from ACT to RD/WR, must be >= 1
T_CAS, 2, cycles from RD/WR to done, must be >= 1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_we  in  1  1 = write, 0 = read
req_bank_id  in  $clog2(NUM_OF_BANKS)  decoded bank
req_row_id  in  $clog2(NUM_OF_ROWS)  decoded row
req_col_id  in  $clog2(NUM_OF_COLS)  decoded column
cmd_valid  out  1  command issued this cycle
cmd  out  3  command code: NOP=0, ACT=1, RD=2, WR=3, PRE=4
cmd_bank  out  $clog2(NUM_OF_BANKS)  target bank of cmd
cmd_row  out  $clog2(NUM_OF_ROWS)  row; valid for ACT, 0 otherwise
cmd_col  out  $clog2(NUM_OF_COLS)  column; valid for RD/WR, 0 otherwise
done  out  1  one-cycle pulse: request complete
done_hit  out  1  qualifies done: 1 if the request was a row hit

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE, req_ready=1, all other outputs 0, counter 0.
  - Every bank marked closed; the row table is cleared to 0.
- States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW, WAIT_CAS.
- Handshake:
  - Accept only when req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - Accepting latches we/bank/row/col and the hit flag.
  - req_valid while busy is ignored and must be held by the source.
- Decision at acceptance, using the table entry for req_bank_id:
  - open and row equal: hit, go to RW.
  - closed: go to ACT.
  - open and row different: conflict, go to PRE.
- PRE (1 cycle): cmd_valid=1, cmd=PRE, cmd_bank=latched bank. Clear the bank's open bit. Load counter with T_RP-1 and go to WAIT_RP (straight to ACT if T_RP=1).
- ACT (1 cycle): cmd=ACT, cmd_row=latched row. Set the open bit and store the row. Load counter with T_RCD-1 and go to WAIT_RCD (straight to RW if T_RCD=1).
- RW (1 cycle): cmd=WR if we else RD, cmd_col=latched col. Load counter with T_CAS-1 and go to WAIT_CAS (straight to IDLE if T_CAS=1).
- WAIT_* states: cmd_valid=0 and cmd fields 0. Counter decrements each cycle; leave the state when it reaches 0.
- On leaving WAIT_CAS (or RW when T_CAS=1):
  - Return to IDLE.
  - done=1 for exactly one cycle, the first IDLE cycle, with req_ready=1 in that same cycle.
  - done_hit=latched hit flag in that cycle, 0 otherwise.
  - A new request may be accepted in that same cycle.
- Command spacing, all exact:
  - PRE at cycle t → ACT at t+T_RP.
  - ACT at t → RD/WR at t+T_RCD.
  - RD/WR at t → done at t+T_CAS.
- Latency with accept at cycle 0:
  - Hit: done at 1+T_CAS.
  - Closed bank: done at 1+T_RCD+T_CAS.
  - Conflict: done at 1+T_RP+T_RCD+T_CAS.
- Banks are independent: ACT or PRE on one bank never changes another bank's table entry. Rows stay open after RD/WR (open-page policy).
- Outputs are registered from state and latched fields. cmd_valid=0 implies cmd=NOP and all cmd fields are 0.
- Reset mid-operation:
  - Abort immediately: no further commands, no done.
  - All banks return to closed.

Test Plan:
- Reset, then read bank 2 / row 5 / col 3 at cycle 0 → ACT(b2,r5) cycle 1; RD(b2,c3) cycle 4; done=1, done_hit=0 at cycle 6; req_ready low cycles 1-5.
- Then write bank 2 / row 5 / col 7 → WR(b2,c7) 1 cycle after accept; done_hit=1 two cycles later.
- Then read bank 2 / row 9 → PRE(b2) +1, ACT(b2,r9) +4, RD +7, done +9, done_hit=0.
- With bank 2 open at row 9, read bank 5 / row 9 → ACT(b5) with no PRE. A following bank 2 / row 9 request is a hit.
- req_valid held high with a new request during busy → accepted only in the done cycle; back-to-back hits give a done every 1+T_CAS cycles.
- Assert rst_n low during WAIT_RCD → outputs 0 immediately, no done. After release, a read to the same bank/row is treated as closed (ACT issued).
